// File: rtl/mem_scan_ctrl_pkg.sv
// Shared types for the memory sweep engine.
//   scan_mode_t  : sweep flavour (read, fill, fill then verify)
//   scan_state_t : controller states
//   fill_word    : fill data for an address; callers truncate or zero-extend
//                  to their own widths through the FILL_MAX_W-bit form.
package scan_pkg;
  localparam int FILL_MAX_W = 64;

  typedef enum logic [1:0] {
    READ_SWEEP  = 2'b00,
    FILL        = 2'b01,
    FILL_VERIFY = 2'b10
  } scan_mode_t;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} scan_state_t;

  function automatic logic [FILL_MAX_W-1:0] fill_word(input logic [FILL_MAX_W-1:0] addr,
                                                       input logic [FILL_MAX_W-1:0] pattern);
    return addr ^ pattern;
  endfunction
endpackage

// File: rtl/mem_scan_ctrl_if.sv
// Control, memory and result signals of mem_scan_ctrl.
//   master : the scan engine (drives memory strobes and results)
//   slave  : control logic plus memory (drives start/config and rdata)
interface mem_scan_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] pattern;
  logic [ADDR_W-1:0] raddress;
  logic [ADDR_W-1:0] waddress;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic [DATA_W-1:0] rdata;
  logic              scan_valid;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  err_count;

  modport master (
    input  start, mode, base_addr, last_addr, pattern, rdata,
    output raddress, waddress, wdata, wr, scan_valid, scan_addr, scan_data,
           busy, done, error, err_addr, err_count
  );

  modport slave (
    output start, mode, base_addr, last_addr, pattern, rdata,
    input  raddress, waddress, wdata, wr, scan_valid, scan_addr, scan_data,
           busy, done, error, err_addr, err_count
  );
endinterface

// File: rtl/mem_scan_ctrl_delay_line.sv
// scan_delay_line: tracks reads in flight so each returning rdata word can be
// paired with the address that requested it.
//   clock, reset : clock, async active-high reset (clears valid bits only)
//   in_vld/in_addr   : read issued this cycle
//   out_vld/out_addr : read issued STAGES cycles ago, aligned with rdata
module scan_delay_line #(
  parameter int ADDR_W = 32,
  parameter int STAGES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr
);
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][ADDR_W-1:0] addr_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= in_vld;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Address payload needs no reset: it is only looked at under a valid bit.
  always_ff @(posedge clock) begin
    addr_pipe[1] <= in_addr;
    for (int i = 2; i <= STAGES; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_addr = addr_pipe[STAGES];
endmodule

// File: rtl/mem_scan_ctrl.sv
// mem_scan_ctrl: walks base..last (inclusive) with a fixed byte STRIDE over a
// single-port-write, registered-read memory. Reads the range out, fills it
// with addr^pattern, or fills and then verifies it, counting mismatches.
//   clock, reset : clock, async active-high reset
//   bus (master) : start/mode/base_addr/last_addr/pattern config, memory
//                  strobes (raddress, waddress, wdata, wr, rdata), read-sweep
//                  stream (scan_valid/addr/data), status (busy, done, error,
//                  err_addr, err_count)
module mem_scan_ctrl
  import scan_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STRIDE      = 4,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input logic           clock,
  input logic           reset,
  mem_scan_ctrl_if.master bus
);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  scan_state_t       state, state_nxt;
  scan_mode_t        mode_q;
  logic [ADDR_W-1:0] addr_q, base_q, last_q;
  logic [DATA_W-1:0] pat_q;
  logic [LAT_W-1:0]  drain_q;
  logic [ADDR_W:0]   addr_inc;
  logic              at_last, accept, rd_issue;
  logic              dl_vld, scan_vld, mismatch;
  logic [ADDR_W-1:0] dl_addr;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [CNT_W-1:0]  err_cnt_q;

  function automatic logic [DATA_W-1:0] fill_of(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] p);
    return DATA_W'(fill_word(FILL_MAX_W'(a), FILL_MAX_W'(p)));
  endfunction

  // One extra bit so stepping past the top of the address space ends the
  // range instead of wrapping back to 0.
  assign addr_inc = {1'b0, addr_q} + (ADDR_W+1)'(STRIDE);
  assign at_last  = addr_inc > {1'b0, last_q};
  assign accept   = (state == IDLE) && bus.start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.wr       = 1'b0;
    bus.waddress = '0;
    bus.wdata    = '0;
    bus.raddress = '0;
    rd_issue     = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        if (bus.last_addr < bus.base_addr)                      state_nxt = DONE;
        else if (bus.mode == FILL || bus.mode == FILL_VERIFY)   state_nxt = WRITE;
        else                                                    state_nxt = READ;
      end
      WRITE: begin
        bus.wr       = 1'b1;
        bus.waddress = addr_q;
        bus.wdata    = fill_of(addr_q, pat_q);
        if (at_last) state_nxt = (mode_q == FILL_VERIFY) ? READ : DONE;
      end
      READ: begin
        bus.raddress = addr_q;
        rd_issue     = 1'b1;
        if (at_last) state_nxt = DRAIN;
      end
      DRAIN: if (drain_q == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      base_q     <= '0;
      last_q     <= '0;
      pat_q      <= '0;
      mode_q     <= READ_SWEEP;
      drain_q    <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (accept) begin
      addr_q     <= bus.base_addr;
      base_q     <= bus.base_addr;
      last_q     <= bus.last_addr;
      pat_q      <= bus.pattern;
      mode_q     <= (bus.mode == 2'b11) ? READ_SWEEP : scan_mode_t'(bus.mode);
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      // Fill+verify rewinds to base so the read pass starts right after the last write.
      if (state == WRITE && at_last) addr_q <= base_q;
      else if (state == WRITE || state == READ) addr_q <= addr_inc[ADDR_W-1:0];

      if (state == READ)       drain_q <= LAT_W'(MEM_LATENCY - 1);
      else if (state == DRAIN) drain_q <= drain_q - LAT_W'(1);

      if (dl_vld && mode_q == FILL_VERIFY && mismatch) begin
        error_q <= 1'b1;
        if (!error_q)        err_addr_q <= dl_addr;
        if (err_cnt_q != '1) err_cnt_q  <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  scan_delay_line #(.ADDR_W(ADDR_W), .STAGES(MEM_LATENCY)) u_dly (
    .clock    (clock),
    .reset    (reset),
    .in_vld   (rd_issue),
    .in_addr  (addr_q),
    .out_vld  (dl_vld),
    .out_addr (dl_addr)
  );

  assign mismatch       = bus.rdata != fill_of(dl_addr, pat_q);
  assign scan_vld       = dl_vld && (mode_q == READ_SWEEP);
  assign bus.scan_valid = scan_vld;
  assign bus.scan_addr  = scan_vld ? dl_addr : '0;
  assign bus.scan_data  = scan_vld ? bus.rdata : '0;
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
  assign bus.error      = error_q;
  assign bus.err_addr   = err_addr_q;
  assign bus.err_count  = err_cnt_q;
endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed bench for mem_scan_ctrl: registered-read memory model (256 words,
// aliased on addr[9:2]) with optional stuck write at one address, a per-cycle
// sampler at negedge, and hand-computed expectations.
module tb_mem_scan_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_scan_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

  mem_scan_ctrl #(.ADDR_W(32), .DATA_W(32), .STRIDE(4), .MEM_LATENCY(1), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // memory model
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_i  = '0;
  logic [31:0] pre_d  = '0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_a  = '0;
  logic [31:0] wd_eff;

  assign wd_eff = (fault_en && bus.waddress == fault_a) ? ~bus.wdata : bus.wdata;

  always @(posedge clock) begin
    if (pre_we) mem[pre_i] <= pre_d;
    if (bus.wr) mem[bus.waddress[9:2]] <= wd_eff;
    if (bus.wr && bus.waddress[9:2] == bus.raddress[9:2]) bus.rdata <= wd_eff;
    else bus.rdata <= mem[bus.raddress[9:2]];
  end

  int nvec = 0, nerr = 0;
  int done_rel, done_n, busy_n, wr_n;
  logic busy_after, done_after;
  logic [31:0] wa_first, wd_first, wa_last, wd_last;
  logic [31:0] sa [$];
  logic [31:0] sd [$];
  int          sr [$];
  bit          aborted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] i, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_i = i; pre_d = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic sample(input int rel);
    if (bus.busy) busy_n++;
    if (bus.done) begin done_n++; if (done_rel < 0) done_rel = rel; end
    if (bus.wr) begin
      if (wr_n == 0) begin wa_first = bus.waddress; wd_first = bus.wdata; end
      wa_last = bus.waddress; wd_last = bus.wdata; wr_n++;
    end
    if (bus.scan_valid) begin
      sa.push_back(bus.scan_addr); sd.push_back(bus.scan_data); sr.push_back(rel);
    end
  endtask

  // Start one scan; rel=1 is the cycle after the accepting edge.
  task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [31:0] l,
                     input logic [31:0] p, input bit noise, input int abort_at);
    busy_n = 0; done_n = 0; done_rel = -1; wr_n = 0; aborted = 0;
    wa_first = '0; wd_first = '0; wa_last = '0; wd_last = '0;
    sa.delete(); sd.delete(); sr.delete();
    @(negedge clock);
    bus.start = 1'b1; bus.mode = m; bus.base_addr = b; bus.last_addr = l; bus.pattern = p;
    @(negedge clock);
    bus.start = 1'b0;
    for (int rel = 1; rel <= 200; rel++) begin
      if (rel > 1) @(negedge clock);
      if (rel == abort_at) begin
        check("wr_before_reset", 64'(bus.wr), 64'd1);
        reset = 1'b1; bus.start = 1'b0; aborted = 1; return;
      end
      sample(rel);
      if (noise && rel == 4) begin
        bus.start = 1'b1; bus.mode = 2'b00; bus.base_addr = '0;
        bus.last_addr = 32'hFFFF; bus.pattern = ~p;
      end
      if (noise && rel == 5) bus.start = 1'b0;
      if (done_rel > 0) break;
    end
    @(negedge clock);
    busy_after = bus.busy; done_after = bus.done;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr"},         64'(bus.wr),         64'd0);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_done"},       64'(bus.done),       64'd0);
    check({tag, "_scan_valid"}, 64'(bus.scan_valid), 64'd0);
    check({tag, "_raddress"},   64'(bus.raddress),   64'd0);
    check({tag, "_waddress"},   64'(bus.waddress),   64'd0);
    check({tag, "_wdata"},      64'(bus.wdata),      64'd0);
    check({tag, "_scan_addr"},  64'(bus.scan_addr),  64'd0);
    check({tag, "_scan_data"},  64'(bus.scan_data),  64'd0);
    check({tag, "_error"},      64'(bus.error),      64'd0);
    check({tag, "_err_addr"},   64'(bus.err_addr),   64'd0);
    check({tag, "_err_count"},  64'(bus.err_count),  64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.base_addr = '0; bus.last_addr = '0; bus.pattern = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // A: read sweep 0..64, mem = addr*3
    for (int i = 0; i <= 16; i++) preload(8'(i), 32'(i * 12));
    run(2'b00, 32'h0, 32'h40, 32'h0, 1'b0, 0);
    check("A_count", 64'(sa.size()), 64'd17);
    for (int k = 0; k < 17; k++) if (k < sa.size()) begin
      check("A_addr", 64'(sa[k]), 64'(k * 4));
      check("A_data", 64'(sd[k]), 64'(k * 12));
      check("A_rel",  64'(sr[k]), 64'(k + 2));
    end
    check("A_done_rel", 64'(done_rel), 64'd19);
    check("A_busy_n",   64'(busy_n),   64'd19);
    check("A_done_n",   64'(done_n),   64'd1);
    check("A_wr_n",     64'(wr_n),     64'd0);
    check("A_busy_after", 64'(busy_after), 64'd0);
    check("A_done_after", 64'(done_after), 64'd0);

    // B: fill+verify, clean, with a start pulse mid-scan
    run(2'b10, 32'h100, 32'h13C, 32'hA5A5A5A5, 1'b1, 0);
    check("B_wr_n",     64'(wr_n),     64'd16);
    check("B_wa_first", 64'(wa_first), 64'h100);
    check("B_wd_first", 64'(wd_first), 64'hA5A5A4A5);
    check("B_wa_last",  64'(wa_last),  64'h13C);
    check("B_wd_last",  64'(wd_last),  64'hA5A5A499);
    check("B_done_rel", 64'(done_rel), 64'd34);
    check("B_busy_n",   64'(busy_n),   64'd34);
    check("B_scan_n",   64'(sa.size()), 64'd0);
    check("B_error",    64'(bus.error),     64'd0);
    check("B_err_count",64'(bus.err_count), 64'd0);

    // C: fill+verify with a corrupted word at 0x120
    fault_en = 1'b1; fault_a = 32'h120;
    run(2'b10, 32'h100, 32'h13C, 32'hA5A5A5A5, 1'b0, 0);
    fault_en = 1'b0;
    check("C_error",     64'(bus.error),     64'd1);
    check("C_err_addr",  64'(bus.err_addr),  64'h120);
    check("C_err_count", 64'(bus.err_count), 64'd1);
    check("C_done_rel",  64'(done_rel),      64'd34);

    // D: empty range, error state cleared by the new start
    run(2'b01, 32'h20, 32'h10, 32'h0, 1'b0, 0);
    check("D_done_rel", 64'(done_rel), 64'd1);
    check("D_busy_n",   64'(busy_n),   64'd1);
    check("D_wr_n",     64'(wr_n),     64'd0);
    check("D_scan_n",   64'(sa.size()), 64'd0);
    check("D_error",    64'(bus.error),     64'd0);
    check("D_err_count",64'(bus.err_count), 64'd0);
    check("D_busy_after", 64'(busy_after), 64'd0);

    // E: top of address space, no wrap
    preload(8'hFE, 32'h11111111);
    preload(8'hFF, 32'h22222222);
    run(2'b00, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
    check("E_scan_n", 64'(sa.size()), 64'd2);
    if (sa.size() >= 2) begin
      check("E_addr0", 64'(sa[0]), 64'hFFFFFFF8);
      check("E_addr1", 64'(sa[1]), 64'hFFFFFFFC);
      check("E_data1", 64'(sd[1]), 64'h22222222);
    end
    check("E_done_rel", 64'(done_rel), 64'd4);
    run(2'b01, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
    check("E2_wr_n",     64'(wr_n),     64'd2);
    check("E2_wa_first", 64'(wa_first), 64'hFFFFFFF8);
    check("E2_wa_last",  64'(wa_last),  64'hFFFFFFFC);
    check("E2_wd_last",  64'(wd_last),  64'hFFFFFFFC);
    check("E2_done_rel", 64'(done_rel), 64'd3);

    // F: mode 11 behaves as a read sweep
    run(2'b11, 32'h0, 32'h8, 32'h0, 1'b0, 0);
    check("F_scan_n",   64'(sa.size()), 64'd3);
    if (sa.size() >= 3) check("F_data2", 64'(sd[2]), 64'd24);
    check("F_done_rel", 64'(done_rel), 64'd5);
    check("F_wr_n",     64'(wr_n),     64'd0);

    // G: reset in cycle 5 of a fill, then a fresh fill
    run(2'b01, 32'h0, 32'h100, 32'h5A5A0000, 1'b1, 5);
    check("G_aborted", 64'(aborted), 64'd1);
    #1;
    check_idle_outputs("G_rst");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("G_post_busy", 64'(bus.busy), 64'd0);
      check("G_post_done", 64'(bus.done), 64'd0);
    end
    run(2'b01, 32'h40, 32'h4C, 32'h12345678, 1'b0, 0);
    check("G_wr_n",     64'(wr_n),     64'd4);
    check("G_wa_first", 64'(wa_first), 64'h40);
    check("G_wd_last",  64'(wd_last),  64'h12345634);
    check("G_done_rel", 64'(done_rel), 64'd5);
    check("G_mem_4c",   64'(mem[19]),  64'h12345634);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_scan_ctrl.md
# mem_scan_ctrl

Synthesizable memory sweep engine that walks a word-addressed range of a Memoria32-style memory with a configurable stride. It can read the range, fill it, or fill and then verify it. It replaces bench-only address-sweep loops and sits between the control/debug logic and one single-port-write, registered-read memory instance. It is usable both in self-checking benches and as a power-on memory test in the UP top level.

## Interface
Parameters:
- ADDR_W, 32, address width (byte addresses)
- DATA_W, 32, data word width
- STRIDE, 4, byte increment between accesses (power of two, ≥1)
- MEM_LATENCY, 1, memory read latency in cycles (≥1)
- CNT_W, 16, error counter width

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request a scan; sampled only in IDLE
- mode  in  2  00 read sweep, 01 fill, 10 fill+verify, 11 treated as 00
- base_addr  in  ADDR_W  first address, inclusive
- last_addr  in  ADDR_W  upper bound, inclusive
- pattern  in  DATA_W  fill seed
- raddress  out  ADDR_W  memory read address
- waddress  out  ADDR_W  memory write address
- wdata  out  DATA_W  memory write data
- wr  out  1  memory write enable
- rdata  in  DATA_W  memory read data
- scan_valid  out  1  read-sweep data valid strobe
- scan_addr  out  ADDR_W  address belonging to scan_data
- scan_data  out  DATA_W  read-sweep data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky: at least one verify mismatch
- err_addr  out  ADDR_W  address of the first mismatch
- err_count  out  CNT_W  mismatch count, saturating at all-ones

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, start=1: latch base, last, pattern and mode. Clear error, err_addr and err_count.
  - last_addr < base_addr: go to DONE. No memory access occurs.
  - Mode 01 or 10: go to WRITE.
  - Otherwise: go to READ.
- The access set is base + k·STRIDE for every k with that value ≤ last_addr. The next address is computed at ADDR_W+1 bits, so overflow past the top ends the range and never wraps to 0.
- Fill data for address a is a XOR pattern (truncated or zero-extended to DATA_W).
- WRITE: each cycle drive waddress = a, wdata = fill(a), wr = 1. After the last address:
  - mode 10: go to READ with a reset to base.
  - mode 01: go to DONE.
- READ: each cycle drive raddress = a. Push (valid, a) into a MEM_LATENCY-deep delay line. After the last address, go to DRAIN.
- Delay line output, mode 00: scan_valid = 1, with scan_addr and scan_data = rdata.
- Delay line output, mode 10: compare rdata against fill(addr).
  - On mismatch: set error, increment err_count (saturating).
  - On the first mismatch only: capture err_addr.
- DRAIN: wait MEM_LATENCY cycles for in-flight reads, then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Outside the cycles listed above, wr, scan_valid and done are 0.
- start is ignored while busy=1.
- mode, base and other inputs may change mid-scan with no effect, because they were latched at start.

## Timing
- Reset values: raddress 0, waddress 0, wdata 0, wr 0, scan_valid 0, scan_addr 0, scan_data 0, busy 0, done 0, error 0, err_addr 0, err_count 0. State is IDLE.
- Reset asserted mid-scan: wr drops asynchronously and no further access is issued. In-flight reads are discarded and no done pulse is produced.
- Start accepted at edge t: busy = 1 and the first access are both present from cycle t+1.
- N = number of addresses. Cycles from acceptance to the done pulse:
  - mode 01: N+1
  - mode 00: N+MEM_LATENCY+1
  - mode 10: 2N+MEM_LATENCY+1
  - empty range: 1
- Read issued in cycle c produces scan_valid or a compare in cycle c+MEM_LATENCY.
- The first READ cycle directly follows the last WRITE cycle. The memory must return the newly written data: write at edge e, read issued at edge e or later.
- busy falls in the cycle after done. The next start is accepted the same cycle busy=0 is first sampled.

## Structure
- Package scan_pkg: scan_mode_t (READ_SWEEP, FILL, FILL_VERIFY), scan_state_t (the five states), and a function fill_word(addr, pattern).
- Sub-module scan_delay_line: parametrised shift register of {valid, addr}, depth MEM_LATENCY, async reset clearing the valid bits.
- Top FSM, address counter and error tracking live in mem_scan_ctrl.

## Test plan
- Mode 00, base 0, last 64, STRIDE 4, memory preloaded with data = addr·3 → scan_valid on 17 consecutive cycles with addr 0..64 and data 0..192. done arrives at cycle 19 after start.
- Mode 10, base 0x100, last 0x13C, pattern 0xA5A5A5A5 → 16 writes, then 16 reads. error=0, err_count=0. done arrives at cycle 34 after start.
- Mode 10 with the bench corrupting the word at 0x120 after the fill → error=1, err_addr=0x120, err_count=1.
- last 0x10 < base 0x20 → no wr and no scan_valid. done pulses the cycle after start and busy is high for exactly 1 cycle.
- base 0xFFFFFFF8, last 0xFFFFFFFF, STRIDE 4 → exactly 2 accesses (…F8, …FC) and no wrap to 0.
- Reset asserted at cycle 5 of a mode-01 fill → wr=0 immediately and all outputs at reset values. A start after reset release runs a fresh scan correctly. A start pulsed mid-scan is ignored.
